// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 (7,5) convolutional encoder plus 4-state hard-decision Viterbi decoder.
// Latency: encoder 1 cycle; decoder TB_DEPTH accepted symbols (register-exchange survivors).
// Backpressure: none; each path advances only on its enable and holds all state otherwise.
module viterbi_codec #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_enable_i,
    input  logic       enc_d_in,
    output logic       enc_valid_o,
    output logic [1:0] enc_d_out,
    input  logic       dec_enable_i,
    input  logic [1:0] dec_d_in,
    output logic       dec_d_out
);

    typedef logic [PM_W-1:0]     pm_t;
    typedef logic [PM_W:0]       acs_t;
    typedef logic [TB_DEPTH-1:0] sv_t;

    // Expected {g1, g0} symbol leaving trellis state p on input bit u.
    function automatic logic [1:0] exp_sym(input logic u, input logic [1:0] p);
        return {u ^ p[1] ^ p[0], u ^ p[0]};
    endfunction

    function automatic logic [1:0] ham(input logic [1:0] d);
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [1:0] enc_st;

    always_ff @(posedge clk) begin
        if (!rst) begin
            enc_st      <= 2'b00;
            enc_valid_o <= 1'b0;
            enc_d_out   <= 2'b00;
        end else if (enc_enable_i) begin
            enc_d_out   <= {enc_d_in ^ enc_st[1] ^ enc_st[0], enc_d_in ^ enc_st[0]};
            enc_st      <= {enc_d_in, enc_st[1]};
            enc_valid_o <= 1'b1;
        end else begin
            enc_valid_o <= 1'b0;
            enc_d_out   <= 2'b00;
        end
    end

    // ------------------------------------------------------------------
    // Decoder: add-compare-select, normalisation, register exchange
    // ------------------------------------------------------------------
    pm_t  pm     [4];
    sv_t  sv     [4];
    acs_t acs    [4];
    pm_t  pm_nxt [4];
    sv_t  sv_nxt [4];
    logic [3:0] sel;
    acs_t acs_m01, acs_m23, acs_min;

    for (genvar g = 0; g < 4; g++) begin : g_acs
        // Next state {u, x} is reached from {x, 0} or {x, 1} with input u.
        localparam logic [1:0] NS = 2'(g);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};

        logic [1:0] bm0, bm1;
        acs_t       c0, c1;

        assign bm0 = ham(dec_d_in ^ exp_sym(NS[1], P0));
        assign bm1 = ham(dec_d_in ^ exp_sym(NS[1], P1));
        assign c0  = acs_t'(pm[P0]) + acs_t'(bm0);
        assign c1  = acs_t'(pm[P1]) + acs_t'(bm1);
        // Strict compare so a tie keeps the {x,0} predecessor.
        assign sel[g]    = (c1 < c0);
        assign acs[g]    = sel[g] ? c1 : c0;
        assign sv_nxt[g] = {sel[g] ? sv[P1][TB_DEPTH-2:0] : sv[P0][TB_DEPTH-2:0], NS[1]};
        assign pm_nxt[g] = pm_t'(acs[g] - acs_min);
    end

    assign acs_m01 = (acs[1] < acs[0]) ? acs[1] : acs[0];
    assign acs_m23 = (acs[3] < acs[2]) ? acs[3] : acs[2];
    assign acs_min = (acs_m23 < acs_m01) ? acs_m23 : acs_m01;

    // Best state on the registered metrics, lowest index winning ties.
    logic [1:0] best_01, best_23, best;
    pm_t        best_v01, best_v23;

    assign best_01  = (pm[1] < pm[0]) ? 2'd1 : 2'd0;
    assign best_23  = (pm[3] < pm[2]) ? 2'd3 : 2'd2;
    assign best_v01 = pm[best_01];
    assign best_v23 = pm[best_23];
    assign best     = (best_v23 < best_v01) ? best_23 : best_01;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                pm[i] <= (i == 0) ? pm_t'(0) : pm_t'(16);
                sv[i] <= '0;
            end
            dec_d_out <= 1'b0;
        end else if (dec_enable_i) begin
            for (int i = 0; i < 4; i++) begin
                pm[i] <= pm_nxt[i];
                sv[i] <= sv_nxt[i];
            end
            dec_d_out <= sv[best][TB_DEPTH-1];
        end
    end

endmodule

// File: tb/tb_viterbi_codec.sv
// Directed bench for viterbi_codec: encoder vectors plus encoder->register->decoder loopback.
module tb_viterbi_codec;
    localparam int TB = 16;

    logic       clk;
    logic       rst;
    logic       enc_enable_i;
    logic       enc_d_in;
    logic       enc_valid_o;
    logic [1:0] enc_d_out;
    logic       dec_enable_i;
    logic [1:0] dec_d_in;
    logic       dec_d_out;

    viterbi_codec #(.TB_DEPTH(TB), .PM_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_enable_i (enc_enable_i),
        .enc_d_in     (enc_d_in),
        .enc_valid_o  (enc_valid_o),
        .enc_d_out    (enc_d_out),
        .dec_enable_i (dec_enable_i),
        .dec_d_in     (dec_d_in),
        .dec_d_out    (dec_d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic bits[$];
    int   dec_cnt;
    int   sym_cnt;
    logic flip_mask [0:1023];
    int   mism;
    int   mism_strict;
    int   ign_lo;
    int   ign_hi;
    logic prev_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive encoder/reset, score the decoder output, then load the channel register.
    task automatic cycle(input logic e_en, input logic e_bit, input logic rst_v);
        logic will_acc;
        logic exp_b;
        int   n;
        rst          = rst_v;
        enc_enable_i = e_en;
        enc_d_in     = e_bit;
        will_acc     = dec_enable_i && rst_v;
        @(posedge clk);
        #1;
        if (!rst_v) begin
            bits.delete();
            dec_cnt = 0;
            sym_cnt = 0;
        end else begin
            if (will_acc) begin
                n     = dec_cnt - TB;
                exp_b = (n >= 0 && n < bits.size()) ? bits[n] : 1'b0;
                if (dec_d_out !== exp_b) begin
                    mism++;
                    if (n < ign_lo || n > ign_hi) mism_strict++;
                end
                dec_cnt++;
            end else if (dec_d_out !== prev_out) begin
                mism++;
                mism_strict++;
            end
            if (e_en) bits.push_back(e_bit);
        end
        prev_out     = dec_d_out;
        dec_enable_i = enc_valid_o;
        dec_d_in     = enc_d_out;
        if (enc_valid_o) begin
            if (sym_cnt < 1024 && flip_mask[sym_cnt]) dec_d_in[0] = ~dec_d_in[0];
            sym_cnt++;
        end
    endtask

    task automatic run_stream(input int n, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    cycle(1'b0, 1'b0, 1'b1);
                    if (g == 0) begin
                        chk("gap_enc_valid", enc_valid_o, 1'b0);
                        chk("gap_enc_dout", enc_d_out, 2'b00);
                    end
                end
            end
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic clear_stats();
        mism        = 0;
        mism_strict = 0;
        ign_lo      = -1000;
        ign_hi      = -1000;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        for (int i = 0; i < 1024; i++) flip_mask[i] = 1'b0;
        clear_stats();

        // Reset held two cycles with both enables high
        rst          = 1'b0;
        enc_enable_i = 1'b1;
        enc_d_in     = 1'b1;
        dec_enable_i = 1'b1;
        dec_d_in     = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enc_valid", enc_valid_o, 1'b0);
        chk("rst_enc_dout", enc_d_out, 2'b00);
        chk("rst_dec_dout", dec_d_out, 1'b0);
        bits.delete();
        dec_cnt      = 0;
        sym_cnt      = 0;
        dec_enable_i = 1'b0;
        dec_d_in     = 2'b00;
        prev_out     = 1'b0;

        // Encoder impulse response 11,10,11,00
        cycle(1'b1, 1'b1, 1'b1);
        chk("imp0_valid", enc_valid_o, 1'b1);
        chk("imp0_sym", enc_d_out, 2'b11);
        cycle(1'b1, 1'b0, 1'b1);
        chk("imp1_valid", enc_valid_o, 1'b1);
        chk("imp1_sym", enc_d_out, 2'b10);
        cycle(1'b1, 1'b0, 1'b1);
        chk("imp2_valid", enc_valid_o, 1'b1);
        chk("imp2_sym", enc_d_out, 2'b11);
        cycle(1'b1, 1'b0, 1'b1);
        chk("imp3_valid", enc_valid_o, 1'b1);
        chk("imp3_sym", enc_d_out, 2'b00);

        // Error-free loopback, 256 bits plus flush
        cycle(1'b0, 1'b0, 1'b0);
        clear_stats();
        run_stream(256 + TB, -1, 0);
        chk("clean_mismatches", mism, 0);

        // Two-symbol error bursts on bit 0, spaced well apart
        cycle(1'b0, 1'b0, 1'b0);
        clear_stats();
        for (int k = 0; k < 4; k++) begin
            e = 30 + 60 * k + int'($urandom_range(0, 5));
            flip_mask[e]     = 1'b1;
            flip_mask[e + 1] = 1'b1;
        end
        run_stream(256 + TB, -1, 0);
        chk("burst2_mismatches", mism, 0);
        for (int i = 0; i < 1024; i++) flip_mask[i] = 1'b0;

        // Four-symbol burst: bounded damage, clean after recovery window
        cycle(1'b0, 1'b0, 1'b0);
        clear_stats();
        for (int i = 100; i < 104; i++) flip_mask[i] = 1'b1;
        ign_lo = 100 - TB;
        ign_hi = 103 + 2 * TB;
        run_stream(256 + TB, -1, 0);
        chk("burst4_bounded", (mism <= 2 * TB), 1'b1);
        chk("burst4_recovered", mism_strict, 0);
        for (int i = 0; i < 1024; i++) flip_mask[i] = 1'b0;

        // Five-cycle enable gap mid-stream
        cycle(1'b0, 1'b0, 1'b0);
        clear_stats();
        run_stream(256 + TB, 120, 5);
        chk("gap_mismatches", mism, 0);

        // Mid-stream reset, then a fresh stream
        cycle(1'b0, 1'b0, 1'b0);
        clear_stats();
        run_stream(100, -1, 0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("mid_rst_enc_valid", enc_valid_o, 1'b0);
        chk("mid_rst_enc_dout", enc_d_out, 2'b00);
        chk("mid_rst_dec_dout", dec_d_out, 1'b0);
        clear_stats();
        run_stream(256 + TB, -1, 0);
        chk("post_rst_mismatches", mism, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/viterbi_codec.md
# viterbi_codec

Rate-1/2, constraint-length-3 convolutional encoder and matching 4-state hard-decision Viterbi decoder, packaged as one block with independent encode and decode paths on a shared clock. The encoder feeds the channel; the decoder takes the channel symbols, possibly corrupted, and recovers the data stream after a fixed traceback latency. Used in the TX/RX loopback where the channel model injects short error bursts.

## Interface
- TB_DEPTH, default 16: survivor register length (traceback depth), in bits; must be ≥ 8.
- PM_W, default 8: path-metric width, in bits.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset; synchronous and active-low (sampled on the rising edge of clk).
- enc_enable_i  input  1  encoder accepts enc_d_in this cycle.
- enc_d_in  input  1  data bit to encode.
- enc_valid_o  output  1  enc_d_out holds a valid symbol.
- enc_d_out  output  2  coded symbol, {g1 bit, g0 bit}.
- dec_enable_i  input  1  decoder accepts dec_d_in this cycle.
- dec_d_in  input  2  received symbol, same bit order as enc_d_out.
- dec_d_out  output  1  decoded bit.

## Operation
- Encoder state s[1:0] = {previous bit, bit before that}; reset value 0.
- On an edge with enc_enable_i=1 and input u: enc_d_out <= {u^s[1]^s[0], u^s[0]} (generators 7, 5 octal); s <= {u, s[1]}; enc_valid_o <= 1.
- On an edge with enc_enable_i=0: enc_valid_o <= 0, enc_d_out <= 0, s holds.
- Decoder trellis: state {b[t-1], b[t-2]}. Next state ns={u, x} has two predecessors, p0={x,0} and p1={x,1}. The expected symbol for predecessor p with input u is {u^p[1]^p[0], u^p[0]}.
- Branch metric: Hamming distance (0..2) between dec_d_in and the expected symbol.
- ACS for each ns: candidate metric = PM[p] + BM. Pick the smaller; on a tie, pick p0.
- Normalization: after ACS, subtract the minimum of the 4 new metrics from all four. Metrics are unsigned PM_W bits and never overflow.
- Survivors use register exchange: SV[ns] <= {SV[chosen p][TB_DEPTH-2:0], u}.
- Output: on each accepting edge, dec_d_out <= SV[best][TB_DEPTH-1]. SV and PM here are the pre-update registered values. best is the state with minimum PM, lowest index on a tie.
- Decoder reset: PM[0]=0; PM[1..3]=16. All SV=0. dec_d_out=0.
- When dec_enable_i=0, PM, SV and dec_d_out hold.
- Correction capability: free distance 5. Two single-bit symbol errors are corrected when all other symbols within ±TB_DEPTH are error-free.

## Timing
- Reset values: enc_valid_o=0, enc_d_out=0, dec_d_out=0. Reset overrides the enables in the same cycle.
- Encoder latency: 1 cycle. The symbol for the bit sampled at edge k is visible after edge k.
- Decoder latency: the bit carried by the n-th accepted symbol (n from 0) appears on dec_d_out after the edge accepting symbol n+TB_DEPTH. For TB_DEPTH=16, that is 16 accepted symbols later.
- The first TB_DEPTH outputs after reset are 0, the reset survivor content.
- Gaps in dec_enable_i stretch the latency in cycles but not in symbols. The two paths are fully independent.
- Reset mid-stream clears all state on that edge; the next accepted symbol is treated as the first.
- Loopback use: dec_d_in = enc_d_out registered once, and dec_enable_i = enc_valid_o registered once, so both stay aligned.

## Test plan
- Reset: hold rst=0 for 2 cycles with both enables high -> enc_valid_o=0, enc_d_out=00, dec_d_out=0.
- Encoder impulse: enc_d_in = 1,0,0,0 with enable high -> enc_d_out = 11,10,11,00; enc_valid_o=1 from the first edge.
- Error-free loopback: 256 random bits through the encoder, one register stage, then the decoder. dec_d_out equals the input delayed 16 accepted symbols, with zero mismatches.
- Burst errors: same loopback, flipping bit 0 of 2 consecutive symbols at random times at least 40 symbols apart -> zero decoded mismatches. Four consecutive flips must produce a finite mismatch count with no lock-up; clean decoding resumes within 2×TB_DEPTH symbols.
- Enable gaps: deassert dec_enable_i for 5 cycles mid-stream -> dec_d_out holds, and the decoded sequence is unchanged apart from the 5-cycle shift.
- Mid-stream reset: pulse rst low for 1 cycle after 100 bits -> the outputs return to reset values, then the next 256-bit stream decodes error-free with 16-symbol latency.
